retire_multi: RTL
=================

RETIRE_MULTI -- requirements
Module: retire_multi

Interface
REQ-001 SHALL have parameter COMMIT_WIDTH, default 2, meaning the maximum number of ROB head entries committed per cycle (legal range 1..8).
REQ-002 SHALL have parameter PHY_RF_ADDR_WIDTH, default 6, meaning the physical register address width.
REQ-003 SHALL have parameter XLEN, default 32, meaning the data, address and PC width.
REQ-004 SHALL have these ports (N = COMMIT_WIDTH, P = PHY_RF_ADDR_WIDTH, slot 0 = oldest):
- clk  in  1  sole clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- head_valid  in  N  ROB slot i holds an entry.
- head_ready  in  N  slot i result complete.
- head_is_store  in  N  slot i is a store.
- head_has_dest  in  N  slot i frees an old physical register.
- head_mispredict  in  N  slot i is a mispredicted branch.
- head_old_phy  in  N*P  physical register to free, per slot.
- head_target  in  N*XLEN  redirect PC, per slot.
- head_st_addr  in  N*XLEN  store address, per slot.
- head_st_data  in  N*XLEN  store data, per slot.
- commit_cnt  out  $clog2(N+1)  entries the ROB pops at this edge.
- free_en  out  N  free-list return strobe, per slot.
- free_addr  out  N*P  register returned, per slot.
- dmem_wr_en  out  1  store request.
- dmem_addr  out  XLEN  store address.
- dmem_data  out  XLEN  store data.
- dmem_valid_in  in  1  store acknowledge.
- mispredicted_branch  out  1  one-cycle flush pulse.
- pc_to_jump  out  XLEN  redirect target, valid while flushing.
- instret  out  64  retired-instruction counter.

Function
REQ-005 SHALL implement a state machine with states IDLE, ST_WAIT and FLUSH.
REQ-006 In IDLE, slot i SHALL commit iff all of the following hold:
- all slots below i commit;
- head_valid[i] and head_ready[i];
- head_is_store[i]=0;
- no slot below i has head_mispredict=1.
REQ-007 commit_cnt SHALL equal the number of committing slots and SHALL be combinational, with zero latency from the head inputs.
REQ-008 free_en[i] SHALL be 1 iff slot i commits and head_has_dest[i]=1; free_addr slot i SHALL mirror head_old_phy slot i.
REQ-009 A non-contiguous valid pattern (a slot with head_valid=0) SHALL terminate the commit group at that slot.
REQ-010 When a committing slot has head_mispredict=1 it SHALL be the last slot committed that cycle, and the state SHALL go to FLUSH with pc_to_jump registered from that slot's head_target.
REQ-011 In FLUSH, mispredicted_branch SHALL be 1 for exactly one cycle with commit_cnt=0 and free_en=0, then the state SHALL return to IDLE.
REQ-012 In IDLE with slot 0 valid, ready and a store, commit_cnt SHALL be 0 and the state SHALL go to ST_WAIT, registering head_st_addr and head_st_data of slot 0.
REQ-013 A store in slot i>0 SHALL end the group before slot i; it waits until it reaches slot 0.
REQ-014 In ST_WAIT, dmem_wr_en SHALL be held at 1 with stable dmem_addr and dmem_data until dmem_valid_in=1.
REQ-015 On the cycle dmem_valid_in=1 in ST_WAIT:
- commit_cnt SHALL be 1;
- free_en[0] SHALL equal head_has_dest[0];
- dmem_wr_en SHALL remain 1 that cycle and be 0 from the next cycle;
- the state SHALL go to IDLE;
- no other slot SHALL commit that cycle.
REQ-016 A store whose head_mispredict=1 SHALL be treated as a store; head_mispredict SHALL be ignored for store slots.
REQ-017 dmem_valid_in SHALL be ignored outside ST_WAIT.
REQ-018 instret SHALL add commit_cnt at every rising edge and wrap modulo 2^64.
REQ-019 Outside FLUSH, pc_to_jump SHALL hold its last registered value.

Reset
REQ-020 While rst=1, regardless of clk:
- state SHALL be IDLE;
- instret, pc_to_jump, dmem_addr and dmem_data SHALL be 0;
- dmem_wr_en, mispredicted_branch, commit_cnt and free_en SHALL be 0.
REQ-021 Reset asserted during ST_WAIT or FLUSH SHALL abandon the operation; no commit, pulse or write SHALL occur after deassertion.

Verification
REQ-022 The bench SHALL cover these directed scenarios (N=2):
- Slots 0,1 valid and ready, non-store, has_dest=1, old_phy=3,4 -> commit_cnt=2, free_en=11, free_addr={4,3}; instret +2 next edge.
- Slot 0 ready, slot 1 valid but not ready -> commit_cnt=1; slot 1 not freed.
- Slot 0 mispredict with target=0x40, slot 1 ready -> commit_cnt=1; next cycle mispredicted_branch=1, pc_to_jump=0x40, commit_cnt=0; then IDLE.
- Slot 0 store with addr=0x100, data=0xAB, ack after 3 cycles -> dmem_wr_en high 4 cycles with addr=0x100, data=0xAB; commit_cnt=1 only on the ack cycle.
- Slot 0 non-store, slot 1 store -> commit_cnt=1; store enters ST_WAIT next cycle from slot 0.
- rst asserted mid ST_WAIT -> dmem_wr_en=0 immediately and instret=0; ack after deassertion -> commit_cnt=0.

Source files
------------

// File: rtl/retire_multi.sv
// rtl/retire_multi.sv - multi-slot ROB retirement with store handshake and mispredict flush
// Oldest-first in-order commit of up to COMMIT_WIDTH head entries per cycle.
module retire_multi #(
  parameter int COMMIT_WIDTH      = 2,
  parameter int PHY_RF_ADDR_WIDTH = 6,
  parameter int XLEN              = 32
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [COMMIT_WIDTH-1:0]                     head_valid,
  input  logic [COMMIT_WIDTH-1:0]                     head_ready,
  input  logic [COMMIT_WIDTH-1:0]                     head_is_store,
  input  logic [COMMIT_WIDTH-1:0]                     head_has_dest,
  input  logic [COMMIT_WIDTH-1:0]                     head_mispredict,
  input  logic [COMMIT_WIDTH*PHY_RF_ADDR_WIDTH-1:0]   head_old_phy,
  input  logic [COMMIT_WIDTH*XLEN-1:0]                head_target,
  input  logic [COMMIT_WIDTH*XLEN-1:0]                head_st_addr,
  input  logic [COMMIT_WIDTH*XLEN-1:0]                head_st_data,
  output logic [$clog2(COMMIT_WIDTH+1)-1:0]           commit_cnt,
  output logic [COMMIT_WIDTH-1:0]                     free_en,
  output logic [COMMIT_WIDTH*PHY_RF_ADDR_WIDTH-1:0]   free_addr,
  output logic                                        dmem_wr_en,
  output logic [XLEN-1:0]                             dmem_addr,
  output logic [XLEN-1:0]                             dmem_data,
  input  logic                                        dmem_valid_in,
  output logic                                        mispredicted_branch,
  output logic [XLEN-1:0]                             pc_to_jump,
  output logic [63:0]                                 instret
);

  localparam int N  = COMMIT_WIDTH;
  localparam int CW = $clog2(COMMIT_WIDTH+1);

  typedef enum logic [1:0] {IDLE, ST_WAIT, FLUSH} state_t;

  state_t          state;
  logic [CW-1:0]   cnt_c;
  logic [N-1:0]    free_c;
  logic            go;
  logic            mp_hit;
  logic [XLEN-1:0] mp_tgt;
  logic            store_go;
  logic            wr_q;
  logic            flush_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] data_q;
  logic [XLEN-1:0] pc_q;
  logic [63:0]     instret_q;

  // Only slot 0 ever launches a store; younger slots' store fields are ignored.
  logic unused_slots;
  assign unused_slots = ^{head_st_addr, head_st_data};

  always_comb begin
    cnt_c    = '0;
    free_c   = '0;
    go       = 1'b1;
    mp_hit   = 1'b0;
    mp_tgt   = '0;
    store_go = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          // A slot commits only while every older slot committed and no older branch mispredicted.
          for (int i = 0; i < N; i++) begin
            if (go && head_valid[i] && head_ready[i] && !head_is_store[i]) begin
              cnt_c     = cnt_c + CW'(1);
              free_c[i] = head_has_dest[i];
              if (head_mispredict[i]) begin
                go     = 1'b0;
                mp_hit = 1'b1;
                mp_tgt = head_target[i*XLEN +: XLEN];
              end
            end else begin
              go = 1'b0;
            end
          end
          store_go = head_valid[0] && head_ready[0] && head_is_store[0];
        end
        ST_WAIT: begin
          if (dmem_valid_in) begin
            cnt_c     = CW'(1);
            free_c[0] = head_has_dest[0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wr_q      <= 1'b0;
      flush_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      pc_q      <= '0;
      instret_q <= '0;
    end else begin
      instret_q <= instret_q + 64'(cnt_c);
      case (state)
        IDLE: begin
          if (mp_hit) begin
            state   <= FLUSH;
            flush_q <= 1'b1;
            pc_q    <= mp_tgt;
          end else if (store_go) begin
            state  <= ST_WAIT;
            wr_q   <= 1'b1;
            addr_q <= head_st_addr[XLEN-1:0];
            data_q <= head_st_data[XLEN-1:0];
          end
        end
        ST_WAIT: begin
          if (dmem_valid_in) begin
            state <= IDLE;
            wr_q  <= 1'b0;
          end
        end
        FLUSH: begin
          state   <= IDLE;
          flush_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          wr_q    <= 1'b0;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  assign commit_cnt          = cnt_c;
  assign free_en             = free_c;
  assign free_addr           = head_old_phy;
  assign dmem_wr_en          = wr_q;
  assign dmem_addr           = addr_q;
  assign dmem_data           = data_q;
  assign mispredicted_branch = flush_q;
  assign pc_to_jump          = pc_q;
  assign instret             = instret_q;

endmodule
